// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 decrypt sequencer.
//   AES_W          : block/key width
//   SETTLE_DEFAULT : default number of cycles the core inputs are held stable
//   state_t        : sequencer state encoding
//   FIPS_*         : FIPS-197 AES-128 known-answer vectors
package aes_pkg;

    localparam int unsigned AES_W          = 128;
    localparam int unsigned SETTLE_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [AES_W-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [AES_W-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [AES_W-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector (bit 0 = requester 0)
//   update_en  : grant is taken this cycle; advance the pointer
//   grant      : one-hot grant (all zero when no request)
// The pointer resets to 1 so requester 0 wins the first contested round.
module aes_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update_en,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (update_en) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/aes_dec_sched.sv
// Sequencer sharing one combinational AES-128 decrypt core between two
// requesters. The core is a multicycle path: its block/key inputs come from
// registers held stable for SETTLE_CYCLES cycles before the result is taken.
//   clk, rst_n            : clock, asynchronous active-low reset
//   key_wr, key_in        : key register write (accepted only when idle)
//   key_err               : one-cycle pulse when a key write was dropped
//   reqN_valid/ready/block: requester N ciphertext handshake
//   rsp_valid/ready/data/id : plaintext response, tagged with requester
//   core_block, core_key  : registered inputs to the shared core
//   core_result           : shared core output
//   busy                  : high whenever not idle
module aes_dec_sched
    import aes_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_DEFAULT,
    parameter int unsigned W             = AES_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_wr,
    input  logic [W-1:0] key_in,
    output logic         key_err,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_block,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_block,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_id,
    output logic [W-1:0] core_block,
    output logic [W-1:0] core_key,
    input  logic [W-1:0] core_result,
    output logic         busy
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] grant;
    logic       accept;
    logic [3:0] cnt;

    aes_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({req1_valid, req0_valid}),
        .update_en (accept),
        .grant     (grant)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|grant)         state_nxt = RUN;
            RUN:     if (cnt == 4'd0)    state_nxt = RESP;
            RESP:    if (rsp_ready)      state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; grants are only visible while idle
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        busy       = (state != IDLE);
        if (state == IDLE) begin
            req0_ready = grant[0];
            req1_ready = grant[1];
            accept     = |grant;
        end
    end

    // Datapath registers. The key write and a grant may share an idle cycle:
    // both core_key and core_block update on that edge, so the granted block
    // is decrypted with the new key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_err    <= 1'b0;
            core_key   <= '0;
            core_block <= '0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            cnt        <= '0;
        end else begin
            key_err <= key_wr && (state != IDLE);
            if (key_wr && (state == IDLE)) begin
                core_key <= key_in;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        core_block <= grant[1] ? req1_block : req0_block;
                        rsp_id     <= grant[1];
                        cnt        <= CNT_LOAD;
                    end
                end
                RUN: begin
                    if (cnt == 4'd0) begin
                        rsp_data  <= core_result;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_sched.sv
module tb_aes_dec_sched;

    localparam logic [127:0] K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B2     = 128'hdeadbeef0123456789abcdeffedcba98;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_wr;
    logic [127:0] key_in;
    logic         key_err;
    logic         req0_valid, req0_ready;
    logic [127:0] req0_block;
    logic         req1_valid, req1_ready;
    logic [127:0] req1_block;
    logic         rsp_valid, rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_id;
    logic [127:0] core_block, core_key, core_result;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         id;
        logic [127:0] data;
    } exp_t;
    exp_t exp_q[$];
    logic exp_last;

    aes_dec_sched #(.SETTLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_wr      (key_wr),
        .key_in      (key_in),
        .key_err     (key_err),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_block  (req0_block),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_block  (req1_block),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .core_block  (core_block),
        .core_key    (core_key),
        .core_result (core_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the decrypt core: exact on the FIPS vector, an arbitrary
    // key-dependent mix elsewhere.
    function automatic logic [127:0] core_model(input logic [127:0] b, input logic [127:0] k);
        if (b == CT && k == K_FIPS) return PT;
        return b ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
    endfunction

    always_comb core_result = core_model(core_block, core_key);

    task automatic write_key(input logic [127:0] k);
        @(negedge clk);
        key_wr = 1'b1;
        key_in = k;
        @(negedge clk);
        key_wr = 1'b0;
    endtask

    task automatic wait_rsp(inout int n);
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_wr = 1'b0; key_in = '0;
        req0_valid = 1'b0; req0_block = '0;
        req1_valid = 1'b0; req1_block = '0;
        rsp_ready = 1'b1;
        exp_last = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL rst_rsp_id: got %b want 0", rsp_id); end
        checks++; if (core_block !== '0) begin errors++; $display("FAIL rst_core_block: got %h want 0", core_block); end
        checks++; if (core_key !== '0) begin errors++; $display("FAIL rst_core_key: got %h want 0", core_key); end
        checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL rst_key_err: got %b want 0", key_err); end
        checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", {req1_ready, req0_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int n;
        exp_t e;
        write_key(K_FIPS);
        #1;
        checks++; if (core_key !== K_FIPS) begin errors++; $display("FAIL single_key: got %h want %h", core_key, K_FIPS); end
        @(negedge clk);
        req0_valid = 1'b1; req0_block = CT; rsp_ready = 1'b1;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", {req1_ready, req0_ready}); end
        exp_q.push_back('{id: 1'b0, data: core_model(CT, K_FIPS)});
        exp_last = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        n = 1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_once: got %b want 0", req0_ready); end
        checks++; if (core_block !== CT) begin errors++; $display("FAIL single_core_block: got %h want %h", core_block, CT); end
        wait_rsp(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL single_latency: got %0d want 5", n); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL single_sb: got empty want entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL single_data: got %h want %h", rsp_data, e.data); end
            checks++; if (rsp_id !== e.id) begin errors++; $display("FAIL single_id: got %b want %b", rsp_id, e.id); end
        end
        @(negedge clk);
        #1;
        checks++; if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("FAIL single_idle: got %b want 00", {busy, rsp_valid}); end
    endtask

    task automatic test_arbitration();
        int grants = 0;
        int got = 0;
        exp_t e;
        req0_block = CT; req1_block = CT; rsp_ready = 1'b1;
        for (int c = 0; c < 80 && (grants < 4 || exp_q.size() != 0); c++) begin
            @(negedge clk);
            req0_valid = (grants < 4);
            req1_valid = (grants < 4);
            #1;
            checks++; if (req0_ready && req1_ready) begin errors++; $display("FAIL arb_onehot: got 11 want at most one"); end
            if (req0_ready || req1_ready) begin
                checks++;
                if (req1_ready !== ~exp_last) begin errors++; $display("FAIL arb_order: got %b want %b", req1_ready, ~exp_last); end
                exp_last = req1_ready;
                exp_q.push_back('{id: req1_ready, data: core_model(CT, K_FIPS)});
                grants++;
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL arb_sb: got empty want entry"); end
                else begin
                    e = exp_q.pop_front();
                    checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL arb_data: got %h want %h", rsp_data, e.data); end
                    checks++; if (rsp_id !== e.id) begin errors++; $display("FAIL arb_id: got %b want %b", rsp_id, e.id); end
                end
                got++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (got !== 4) begin errors++; $display("FAIL arb_count: got %0d want 4", got); end
    endtask

    task automatic test_backpressure();
        int n;
        exp_t e;
        e = '0;
        @(negedge clk);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_block = B2;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_grant: got %b want 1", req0_ready); end
        exp_q.push_back('{id: 1'b0, data: core_model(B2, K_FIPS)});
        exp_last = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_block = CT;
        #1;
        n = 1;
        wait_rsp(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL bp_latency: got %0d want 5", n); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_sb: got empty want entry"); end
        else e = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", rsp_valid); end
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL bp_hold_data: got %h want %h", rsp_data, e.data); end
            checks++; if (rsp_id !== e.id) begin errors++; $display("FAIL bp_hold_id: got %b want %b", rsp_id, e.id); end
            checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL bp_no_grant: got %b want 00", {req1_ready, req0_ready}); end
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("FAIL bp_idle: got %b want 00", {busy, rsp_valid}); end
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_regrant: got %b want 1", req1_ready); end
        req1_valid = 1'b0;
        #1;
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_drop_ready: got %b want 0", req1_ready); end
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_drop_unserved: got %b want 0", busy); end
    endtask

    task automatic test_key_busy();
        int n;
        exp_t e;
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_block = CT;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL kb_grant: got %b want 1", req0_ready); end
        exp_q.push_back('{id: 1'b0, data: core_model(CT, K_FIPS)});
        exp_last = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        key_wr = 1'b1; key_in = '1;
        @(negedge clk);
        key_wr = 1'b0;
        #1;
        checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL kb_err_pulse: got %b want 1", key_err); end
        checks++; if (core_key !== K_FIPS) begin errors++; $display("FAIL kb_key_kept: got %h want %h", core_key, K_FIPS); end
        @(negedge clk);
        #1;
        checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL kb_err_one_cycle: got %b want 0", key_err); end
        n = 3;
        wait_rsp(n);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL kb_sb: got empty want entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL kb_timeout: got %b want 1", rsp_valid); end
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL kb_data: got %h want %h", rsp_data, e.data); end
            checks++; if (rsp_id !== e.id) begin errors++; $display("FAIL kb_id: got %b want %b", rsp_id, e.id); end
        end
        @(negedge clk);
    endtask

    task automatic test_key_and_grant();
        int n;
        exp_t e;
        write_key('0);
        #1;
        checks++; if (core_key !== '0) begin errors++; $display("FAIL kg_zero_key: got %h want 0", core_key); end
        @(negedge clk);
        key_wr = 1'b1; key_in = K_FIPS;
        req1_valid = 1'b1; req1_block = CT;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL kg_grant: got %b want 10", {req1_ready, req0_ready}); end
        exp_q.push_back('{id: 1'b1, data: core_model(CT, K_FIPS)});
        exp_last = 1'b1;
        @(negedge clk);
        key_wr = 1'b0; req1_valid = 1'b0;
        #1;
        checks++; if (core_key !== K_FIPS) begin errors++; $display("FAIL kg_key: got %h want %h", core_key, K_FIPS); end
        checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL kg_no_err: got %b want 0", key_err); end
        n = 1;
        wait_rsp(n);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL kg_sb: got empty want entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL kg_data: got %h want %h", rsp_data, e.data); end
            checks++; if (rsp_id !== e.id) begin errors++; $display("FAIL kg_id: got %b want %b", rsp_id, e.id); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int n;
        exp_t e;
        @(negedge clk);
        req0_valid = 1'b1; req0_block = CT;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_running: got %b want 1", busy); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, rsp_valid, rsp_id, key_err, req1_ready, req0_ready} !== 6'b0) begin
            errors++; $display("FAIL rm_ctrl_zero: got %b want 000000", {busy, rsp_valid, rsp_id, key_err, req1_ready, req0_ready});
        end
        checks++; if ({core_block, core_key, rsp_data} !== '0) begin errors++; $display("FAIL rm_data_zero: got %h/%h/%h want 0", core_block, core_key, rsp_data); end
        exp_q.delete();
        exp_last = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        write_key(K_FIPS);
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_stale_rsp: got %b want 0", rsp_valid); end
        @(negedge clk);
        req0_valid = 1'b1; req0_block = CT;
        req1_valid = 1'b1; req1_block = CT;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL rm_first_grant: got %b want 01", {req1_ready, req0_ready}); end
        exp_q.push_back('{id: 1'b0, data: core_model(CT, K_FIPS)});
        exp_last = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        n = 1;
        wait_rsp(n);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rm_sb: got empty want entry"); end
        else begin
            e = exp_q.pop_front();
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL rm_data: got %h want %h", rsp_data, e.data); end
            checks++; if (rsp_id !== e.id) begin errors++; $display("FAIL rm_id: got %b want %b", rsp_id, e.id); end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_backpressure();
        test_key_busy();
        test_key_and_grant();
        test_reset_mid_run();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drained: got %0d want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_dec_sched.md
Name: aes_dec_sched

Overview:
- Sequencer and two-port round-robin arbiter that shares one combinational AES-128 decrypt core (aesdecrypt: block, key -> result) between two requesters.
- Holds a programmable key register and drives the core's block and key inputs from registers.
- Waits a fixed settle count, because the core is a multicycle path.
- Returns the plaintext with a valid/ready handshake tagged with the requester ID.

Parameters:
- SETTLE_CYCLES, 4, clock cycles the core inputs are held stable before the result is captured; legal range 1..15.
- W, 128, block and key width; fixed for AES-128.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key_wr  in  1  write strobe for key register
- key_in  in  128  new decryption key
- key_err  out  1  one-cycle pulse: key_wr dropped because the block was busy
- req0_valid  in  1  requester 0 has a ciphertext block
- req0_ready  out  1  requester 0 block accepted this cycle
- req0_block  in  128  requester 0 ciphertext
- req1_valid  in  1  requester 1 has a ciphertext block
- req1_ready  out  1  requester 1 block accepted this cycle
- req1_block  in  128  requester 1 ciphertext
- rsp_valid  out  1  plaintext available
- rsp_ready  in  1  consumer accepts plaintext
- rsp_data  out  128  plaintext
- rsp_id  out  1  requester that owns rsp_data
- core_block  out  128  registered block to the shared core
- core_key  out  128  registered key to the shared core
- core_result  in  128  core output
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state=IDLE; settle counter=0; rr pointer last_grant=1, so req0 wins first.
- Reset mid-operation: aborts the transaction; no response is produced.
- FSM states: IDLE, RUN, RESP.

IDLE:
- If any reqN_valid is high, the arbiter picks a winner and reqN_ready is driven combinationally high for that requester only, that cycle.
- At the clock edge: core_block <= winner block; rsp_id <= winner; last_grant <= winner; counter <= SETTLE_CYCLES-1; state <= RUN.
- Both valid: grant the requester != last_grant. One valid: grant it regardless of the pointer.
- The ready signals are never high outside IDLE, and never both high in the same cycle.

RUN:
- core_block and core_key are held constant.
- Counter decrements each cycle.
- When counter==0: rsp_data <= core_result; rsp_valid <= 1; state <= RESP.
- Latency: rsp_valid rises exactly SETTLE_CYCLES cycles after the acceptance edge.

RESP:
- rsp_valid, rsp_data and rsp_id are held stable until rsp_ready is high.
- On the rsp_ready edge: rsp_valid <= 0; state <= IDLE.
- The next grant cannot occur until the cycle after the response handshake; there is no overlap, and throughput is 1 block per SETTLE_CYCLES+2 cycles at best.

Key register:
- core_key is the key register.
- key_wr in IDLE: core_key <= key_in at the edge.
- key_wr in the same IDLE cycle as a grant: the key write takes effect first, so the granted block uses the new key.
- key_wr in RUN or RESP: write ignored; key_err pulses high one cycle.

Other rules:
- The valid inputs of requesters are not required to stay high; a dropped valid before a grant is simply not served.
- No arithmetic beyond the 4-bit down-counter; the counter never wraps because the load value is at most 14.

Decomposition:
- Shared package aes_pkg holds:
  - AES_W=128
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, RESP=2'd2)
  - default SETTLE_CYCLES
  - FIPS-197 test vectors as constants
- One natural sub-module: aes_rr_arb2, a two-input round-robin arbiter with last_grant pointer, grant one-hot and update enable.
- The top-level wrapper instantiates aes_dec_sched alongside aesdecrypt, connecting core_block/core_key/core_result.

Test Plan:
- Single request:
  - Stimulus: key_wr with key 000102030405060708090a0b0c0d0e0f; req0 ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_ready held high.
  - Response: req0_ready for one cycle; rsp_valid exactly 4 cycles after acceptance; rsp_data=00112233445566778899aabbccddeeff; rsp_id=0.
- Arbitration:
  - Stimulus: req0 and req1 both valid continuously with the FIPS ciphertext.
  - Response: grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; never two ready signals in one cycle.
- Backpressure:
  - Stimulus: rsp_ready low for 10 cycles after rsp_valid.
  - Response: rsp_data/rsp_id stable throughout; no new ready grant; IDLE is entered the cycle after rsp_ready rises.
- Key write while busy:
  - Stimulus: key_wr of all-ones during RUN.
  - Response: key_err pulses one cycle; core_key unchanged; result still the FIPS plaintext.
- Key write and grant in the same cycle:
  - Stimulus: key_wr with the FIPS key plus req1 valid, from an all-zero key.
  - Response: the correct FIPS plaintext is returned with rsp_id=1.
- Reset mid-RUN:
  - Stimulus: rst_n low for 2 cycles during RUN.
  - Response: all outputs 0 immediately (asynchronous); after release, req0 is served first when both requesters are valid.
